// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and helpers for the mux select arbiter.
package mux_arb_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  function automatic logic [N_CH-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    return N_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set request scanning from ptr upward, mod 4.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = 0; i < N_CH; i++) begin
      pos = ptr + SEL_W'(i);
      if (!any && req[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin sequencer driving 4:1 mux selects, sampling the mux after a settle delay.
// Optional per-channel saturating grant counters are enabled with MUX_ARB_STATS_EN.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_CH-1:0]       req_i,
  output logic                  s1_o,
  output logic                  s0_o,
  output logic [N_CH-1:0]       grant_o,
  input  logic                  mux_i,
  output logic                  data_o,
  output logic [SEL_W-1:0]      data_ch_o,
  output logic                  data_valid_o,
`ifdef MUX_ARB_STATS_EN
  input  logic                  clr_cnt_i,
  output logic [N_CH*CNT_W-1:0] gnt_cnt_o,
`endif
  input  logic                  data_ready_i
);

  // Handshake: a sample transfers on a rising edge where data_valid_o & data_ready_i;
  // once valid is raised, data_o/data_ch_o/selects stay stable until that edge.

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [N_CH-1:0]  grant_q, grant_d;
  logic             data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             accept;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick u_rr_pick (
    .req (req_i),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          grant_d = idx2onehot(pick_idx);
          cnt_d   = 4'(SETTLE_CYC - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          data_d  = mux_i;
          ch_d    = sel_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (data_ready_i) begin
          accept  = 1'b1;
          valid_d = 1'b0;
          grant_d = '0;
          // Just-served channel drops to lowest priority.
          ptr_d   = sel_q + SEL_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      data_q  <= 1'b0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign s1_o         = sel_q[1];
  assign s0_o         = sel_q[0];
  assign grant_o      = grant_q;
  assign data_o       = data_q;
  assign data_ch_o    = ch_q;
  assign data_valid_o = valid_q;

`ifdef MUX_ARB_STATS_EN
  logic [CNT_W-1:0] gcnt_q [N_CH];
  logic [CNT_W-1:0] gcnt_d [N_CH];

  always_comb begin
    for (int n = 0; n < N_CH; n++) begin
      gcnt_d[n] = gcnt_q[n];
      if (clr_cnt_i) begin
        gcnt_d[n] = '0;
      end else if (accept && (sel_q == SEL_W'(n)) && !(&gcnt_q[n])) begin
        gcnt_d[n] = gcnt_q[n] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 0; n < N_CH; n++) gcnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < N_CH; n++) gcnt_q[n] <= gcnt_d[n];
    end
  end

  always_comb begin
    for (int n = 0; n < N_CH; n++) gnt_cnt_o[n*CNT_W +: CNT_W] = gcnt_q[n];
  end
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with a behavioural 4:1 mux (i0=0,i1=1,i2=0,i3=1) in the loop.
module tb_mux_sel_arbiter;
  import mux_arb_pkg::*;

  localparam int CNT_W = 2;

  logic                  clk;
  logic                  rst_n;
  logic [3:0]            req;
  logic                  s1, s0;
  logic [3:0]            grant;
  logic                  mux_out;
  logic                  data;
  logic [1:0]            data_ch;
  logic                  valid;
  logic                  ready;
  logic                  clr_cnt;
  logic [4*CNT_W-1:0]    gnt_cnt;
  logic [3:0]            mux_in;

  int n_pass   = 0;
  int n_checks = 0;
  int cyc      = 0;
  int t_valid [5];

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mux_in  = 4'b1010;
  assign mux_out = mux_in[{s1, s0}];

  mux_sel_arbiter #(.SETTLE_CYC(1), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .s1_o         (s1),
    .s0_o         (s0),
    .grant_o      (grant),
    .mux_i        (mux_out),
    .data_o       (data),
    .data_ch_o    (data_ch),
    .data_valid_o (valid),
`ifdef MUX_ARB_STATS_EN
    .clr_cnt_i    (clr_cnt),
    .gnt_cnt_o    (gnt_cnt),
`endif
    .data_ready_i (ready)
  );

`ifndef MUX_ARB_STATS_EN
  assign gnt_cnt = '0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at posedge+1; advances until data_valid_o, bounded.
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid_timeout"}, 32'(valid), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; ready = 1'b0; clr_cnt = 1'b0;
    #1;
    check("rst_outputs", {22'd0, s1, s0, grant, data, data_ch, valid},  32'd0);
    do_reset();

    // Idle with no requests
    repeat (3) @(posedge clk);
    #1;
    check("idle_state", 32'(dut.state_q), 32'(IDLE));
    check("idle_outs", {24'd0, grant, data_ch, valid, data}, 32'd0);

    // Single request on ch1, latency
    @(negedge clk);
    req = 4'b0010; ready = 1'b1;
    @(posedge clk); #1;
    check("single_sel", {30'd0, s1, s0}, 32'd1);
    check("single_grant", 32'(grant), 32'h2);
    check("single_novalid", 32'(valid), 32'd0);
    req = 4'b0000;
    @(posedge clk); #1;
    check("single_data", {29'd0, valid, data_ch}, {29'd0, 1'b1, 2'd1});
    check("single_dval", 32'(data), 32'd1);
    @(posedge clk); #1;
    check("single_accept", {27'd0, valid, grant}, 32'd0);

    // Round robin with all requests held, from ptr=0
    do_reset();
    req = 4'b1111; ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      wait_valid("rr");
      t_valid[i] = cyc;
      check($sformatf("rr_ch%0d", i), 32'(data_ch), 32'(i % 4));
      check($sformatf("rr_data%0d", i), 32'(data), 32'(i % 2));
      if (i == 4) req = 4'b0000;
      @(posedge clk); #1;
    end
    for (int i = 1; i < 5; i++)
      check($sformatf("rr_period%0d", i), 32'(t_valid[i] - t_valid[i-1]), 32'd3);

    // Backpressure in HOLD (ptr=1, only ch2 requesting)
    @(negedge clk);
    req = 4'b0100; ready = 1'b0;
    @(posedge clk); #1;
    wait_valid("bp");
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", i), {23'd0, valid, data, data_ch, s1, s0, grant},
            {23'd0, 1'b1, 1'b0, 2'd2, 2'b10, 4'b0100});
    end
    ready = 1'b1;
    @(posedge clk); #1;
    check("bp_accept", {27'd0, valid, grant}, 32'd0);
    check("bp_sel_kept", {30'd0, s1, s0}, 32'd2);

    // Wrap-around: ptr=3, req 1001 -> ch3 then ch0; drop req mid-SETTLE
    @(negedge clk);
    req = 4'b1001;
    @(posedge clk); #1;
    wait_valid("wrap3");
    check("wrap_ch3", {30'd0, data_ch}, 32'd3);
    check("wrap_d3", 32'(data), 32'd1);
    @(posedge clk); #1;
    check("wrap_acc3", 32'(valid), 32'd0);
    @(posedge clk); #1;
    check("wrap_grant0", {26'd0, s1, s0, grant}, {26'd0, 2'b00, 4'b0001});
    check("wrap_settle", 32'(dut.state_q), 32'(SETTLE));
    req = 4'b0000;
    @(posedge clk); #1;
    check("drop_done", {29'd0, valid, data_ch}, {29'd0, 1'b1, 2'd0});
    check("drop_data", 32'(data), 32'd0);

    // Async reset mid-HOLD, no clock edge
    ready = 1'b0;
    @(posedge clk); #1;
    check("mid_hold", 32'(valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {22'd0, s1, s0, grant, data, data_ch, valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MUX_ARB_STATS_EN
    // Saturating counters and clear-over-increment
    req = 4'b0010; ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      wait_valid("cnt");
      @(posedge clk); #1;
      check($sformatf("cnt_ch1_%0d", i), 32'(gnt_cnt[3:2]), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    check("cnt_ch0", 32'(gnt_cnt[1:0]), 32'd0);
    wait_valid("clr");
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    req = 4'b0000;
    check("cnt_clr", 32'(gnt_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
